pwm_channel_gen: RTL and testbench

//  - One PWM output channel, PCA9685-style: compares the shared prescaled period counter against ON/OFF counts.
//  - Sits directly downstream of the prescaled period counter; one instance per output pin.
//  - Double-buffered: host writes land in a shadow set, committed only at period wrap, so no glitch or runt pulses.

---
 rtl/pwm_pkg.sv | 10 +
 rtl/pwm_window_cmp.sv | 25 ++
 rtl/pwm_channel_gen.sv | 70 +++++++
 tb/tb_pwm_channel_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared counter width, limits and ON/OFF register layout for PWM channels
package pwm_pkg;
    localparam int PWM_CNT_W = 12;
    localparam logic [PWM_CNT_W-1:0] CNT_MAX = '1;
    localparam int FULL_BIT = PWM_CNT_W;
    typedef struct packed {
        logic                 full;
        logic [PWM_CNT_W-1:0] cnt;
    } pwm_reg_t;
endpackage

// File: rtl/pwm_window_cmp.sv
// pwm_window_cmp: combinational PWM level from ON/OFF counts and the period counter
module pwm_window_cmp
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic [CNT_W:0]   on,
    input  logic [CNT_W:0]   off,
    input  logic [CNT_W-1:0] cnt,
    output logic             level
);
    logic [CNT_W-1:0] on_c;
    logic [CNT_W-1:0] off_c;
    logic             after_on;
    logic             before_off;
    assign on_c       = on[CNT_W-1:0];
    assign off_c      = off[CNT_W-1:0];
    assign after_on   = cnt >= on_c;
    assign before_off = cnt < off_c;
    // full-off beats full-on; ON>OFF is a window that wraps through zero
    assign level = off[CNT_W]     ? 1'b0 :
                   on[CNT_W]      ? 1'b1 :
                   (on_c < off_c) ? (after_on && before_off) :
                   (on_c > off_c) ? (after_on || before_off) : 1'b0;
endmodule

// File: rtl/pwm_channel_gen.sv
// pwm_channel_gen: double-buffered PWM output channel driven by a shared period counter
// Optional output inversion (invert_i port) is enabled by defining PWM_INVERT_EN.
module pwm_channel_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W          = PWM_CNT_W,
    parameter bit RESET_FULL_OFF = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] counter_i,
    input  logic             wr_valid_i,
    input  logic [CNT_W:0]   wr_on_i,
    input  logic [CNT_W:0]   wr_off_i,
`ifdef PWM_INVERT_EN
    input  logic             invert_i,
`endif
    output logic             pwm_o,
    output logic             period_start_o,
    output logic             wr_pending_o
);
    localparam logic [CNT_W:0] RST_ON  = '0;
    localparam logic [CNT_W:0] RST_OFF = RESET_FULL_OFF ? {1'b1, {CNT_W{1'b0}}} : '0;
    logic [CNT_W-1:0] cnt_prev_r;
    logic [CNT_W:0]   on_r;
    logic [CNT_W:0]   off_r;
    logic [CNT_W:0]   on_sh_r;
    logic [CNT_W:0]   off_sh_r;
    logic [CNT_W:0]   on_nx;
    logic [CNT_W:0]   off_nx;
    logic             wrap;
    logic             level;
    logic             inv;
    assign wrap = (cnt_prev_r == {CNT_W{1'b1}}) && (counter_i == '0);
    // a write landing on the wrap clock bypasses the shadow straight into the active set
    assign on_nx  = !wrap ? on_r  : wr_valid_i ? wr_on_i  : wr_pending_o ? on_sh_r  : on_r;
    assign off_nx = !wrap ? off_r : wr_valid_i ? wr_off_i : wr_pending_o ? off_sh_r : off_r;
`ifdef PWM_INVERT_EN
    assign inv = invert_i;
`else
    assign inv = 1'b0;
`endif
    pwm_window_cmp #(.CNT_W(CNT_W)) u_cmp (
        .on   (on_nx),
        .off  (off_nx),
        .cnt  (counter_i),
        .level(level)
    );
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_prev_r     <= '0;
            on_r           <= RST_ON;
            off_r          <= RST_OFF;
            on_sh_r        <= RST_ON;
            off_sh_r       <= RST_OFF;
            wr_pending_o   <= 1'b0;
            pwm_o          <= 1'b0;
            period_start_o <= 1'b0;
        end else begin
            cnt_prev_r     <= counter_i;
            on_r           <= on_nx;
            off_r          <= off_nx;
            on_sh_r        <= wr_valid_i ? wr_on_i  : on_sh_r;
            off_sh_r       <= wr_valid_i ? wr_off_i : off_sh_r;
            wr_pending_o   <= !wrap && (wr_valid_i || wr_pending_o);
            pwm_o          <= level ^ inv;
            period_start_o <= wrap;
        end
    end
endmodule

// File: tb/tb_pwm_channel_gen.sv
// tb_pwm_channel_gen: directed self-checking bench for pwm_channel_gen
// Build with PWM_INVERT_EN defined to also exercise the inversion port.
module tb_pwm_channel_gen;
    import pwm_pkg::*;
`ifdef PWM_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [11:0] counter_i = '0;
    logic        wr_valid_i = 1'b0;
    logic [12:0] wr_on_i = '0;
    logic [12:0] wr_off_i = '0;
    logic        invert_i = 1'b0;
    logic        pwm_o;
    logic        period_start_o;
    logic        wr_pending_o;
    int          checks = 0;
    int          errors = 0;

    pwm_channel_gen #(.CNT_W(12), .RESET_FULL_OFF(1'b1)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .counter_i     (counter_i),
        .wr_valid_i    (wr_valid_i),
        .wr_on_i       (wr_on_i),
        .wr_off_i      (wr_off_i),
`ifdef PWM_INVERT_EN
        .invert_i      (invert_i),
`endif
        .pwm_o         (pwm_o),
        .period_start_o(period_start_o),
        .wr_pending_o  (wr_pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // reference level: high inside [ON,OFF), or outside [OFF,ON) when the window wraps
    function automatic logic ref_level(input logic [11:0] c, input pwm_reg_t on, input pwm_reg_t off);
        if (off.full) return 1'b0;
        if (on.full) return 1'b1;
        if (on.cnt == off.cnt) return 1'b0;
        if (on.cnt < off.cnt) return c >= on.cnt && c < off.cnt;
        return !(c >= off.cnt && c < on.cnt);
    endfunction

    task automatic test_reset;
        int pulses = 0;
        #1 rst_ni = 1'b0;
        repeat (3) tick;
        checks++; if ({pwm_o, period_start_o, wr_pending_o} !== 3'b000) begin errors++; $display("FAIL reset_outputs: got %b expected 000", {pwm_o, period_start_o, wr_pending_o}); end
        rst_ni = 1'b1;
        for (int p = 0; p < 2; p++) for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            tick;
            if (period_start_o) pulses++;
            checks++; if (pwm_o !== 1'b0) begin errors++; $display("FAIL reset_sweep_pwm p=%0d c=%0d: got %b expected 0", p, c, pwm_o); end
            checks++; if (period_start_o !== (p == 1 && c == 0)) begin errors++; $display("FAIL reset_sweep_start p=%0d c=%0d: got %b", p, c, period_start_o); end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL reset_pulse_count: got %0d expected 1", pulses); end
    endtask

    task automatic test_window;
        pwm_reg_t on = '{1'b0, 12'd100};
        pwm_reg_t off = '{1'b0, 12'd300};
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            wr_valid_i = (c == 150);
            wr_on_i = on;
            wr_off_i = off;
            tick;
            wr_valid_i = 1'b0;
            checks++; if (pwm_o !== 1'b0) begin errors++; $display("FAIL win_old_pwm c=%0d: got %b expected 0", c, pwm_o); end
            checks++; if (period_start_o !== (c == 0)) begin errors++; $display("FAIL win_old_start c=%0d: got %b", c, period_start_o); end
            if (c == 151 || c == 4095) begin
                checks++; if (wr_pending_o !== 1'b1) begin errors++; $display("FAIL win_pending c=%0d: got %b expected 1", c, wr_pending_o); end
            end
        end
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            tick;
            checks++; if (pwm_o !== (c >= 100 && c < 300)) begin errors++; $display("FAIL win_new_pwm c=%0d: got %b", c, pwm_o); end
            checks++; if (period_start_o !== (c == 0)) begin errors++; $display("FAIL win_new_start c=%0d: got %b", c, period_start_o); end
            if (c == 0) begin
                checks++; if (wr_pending_o !== 1'b0) begin errors++; $display("FAIL win_commit_pending: got %b expected 0", wr_pending_o); end
            end
        end
    endtask

    task automatic test_wrap_window;
        pwm_reg_t old_on = '{1'b0, 12'd100};
        pwm_reg_t old_off = '{1'b0, 12'd300};
        pwm_reg_t on = '{1'b0, 12'd4000};
        pwm_reg_t off = '{1'b0, 12'd50};
        logic [3:0] edges = '0;
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            wr_valid_i = (c == 500);
            wr_on_i = on;
            wr_off_i = off;
            tick;
            wr_valid_i = 1'b0;
            checks++; if (pwm_o !== ref_level(12'(c), old_on, old_off)) begin errors++; $display("FAIL wrapwin_old_pwm c=%0d: got %b", c, pwm_o); end
        end
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            tick;
            if (c == 49) edges[3] = pwm_o;
            if (c == 50) edges[2] = pwm_o;
            if (c == 3999) edges[1] = pwm_o;
            if (c == 4000) edges[0] = pwm_o;
            checks++; if (pwm_o !== ref_level(12'(c), on, off)) begin errors++; $display("FAIL wrapwin_new_pwm c=%0d: got %b", c, pwm_o); end
        end
        checks++; if (edges !== 4'b1001) begin errors++; $display("FAIL wrapwin_edges 49/50/3999/4000: got %b expected 1001", edges); end
    endtask

    task automatic test_full;
        pwm_reg_t old_on = '{1'b0, 12'd4000};
        pwm_reg_t old_off = '{1'b0, 12'd50};
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            wr_valid_i = (c == 10);
            wr_on_i = 13'h1000;
            wr_off_i = 13'h1000;
            tick;
            wr_valid_i = 1'b0;
            checks++; if (pwm_o !== ref_level(12'(c), old_on, old_off)) begin errors++; $display("FAIL full_old_pwm c=%0d: got %b", c, pwm_o); end
        end
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            wr_valid_i = (c == 10);
            wr_on_i = 13'h1000;
            wr_off_i = 13'h0000;
            tick;
            wr_valid_i = 1'b0;
            checks++; if (pwm_o !== 1'b0) begin errors++; $display("FAIL full_both_pwm c=%0d: got %b expected 0", c, pwm_o); end
        end
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            tick;
            checks++; if (pwm_o !== 1'b1) begin errors++; $display("FAIL full_on_pwm c=%0d: got %b expected 1", c, pwm_o); end
        end
    endtask

    task automatic test_back_to_back;
        pwm_reg_t a_on = '{1'b0, 12'd10};
        pwm_reg_t a_off = '{1'b0, 12'd20};
        pwm_reg_t b_on = '{1'b0, 12'd1000};
        pwm_reg_t b_off = '{1'b0, 12'd2000};
        pwm_reg_t c_on = '{1'b0, 12'd0};
        pwm_reg_t c_off = '{1'b0, 12'd5};
        pwm_reg_t d_on = '{1'b0, 12'd7};
        pwm_reg_t d_off = '{1'b0, 12'd9};
        pwm_reg_t e_on = '{1'b0, 12'd3000};
        pwm_reg_t e_off = '{1'b0, 12'd3001};
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            wr_valid_i = (c == 5 || c == 6);
            wr_on_i = (c == 5) ? a_on : b_on;
            wr_off_i = (c == 5) ? a_off : b_off;
            tick;
            wr_valid_i = 1'b0;
            checks++; if (pwm_o !== 1'b1) begin errors++; $display("FAIL b2b_hold_pwm c=%0d: got %b expected 1", c, pwm_o); end
            if (c == 7) begin
                checks++; if (wr_pending_o !== 1'b1) begin errors++; $display("FAIL b2b_pending: got %b expected 1", wr_pending_o); end
            end
        end
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            tick;
            checks++; if (pwm_o !== (c >= 1000 && c < 2000)) begin errors++; $display("FAIL b2b_lastwins_pwm c=%0d: got %b", c, pwm_o); end
        end
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            wr_valid_i = (c == 0 || c == 100);
            wr_on_i = (c == 0) ? c_on : d_on;
            wr_off_i = (c == 0) ? c_off : d_off;
            tick;
            wr_valid_i = 1'b0;
            checks++; if (pwm_o !== ref_level(12'(c), c_on, c_off)) begin errors++; $display("FAIL wrapwr_c_pwm c=%0d: got %b", c, pwm_o); end
            if (c == 0) begin
                checks++; if ({pwm_o, period_start_o, wr_pending_o} !== 3'b110) begin errors++; $display("FAIL wrapwr_c_first: got %b expected 110", {pwm_o, period_start_o, wr_pending_o}); end
            end
            if (c == 101) begin
                checks++; if (wr_pending_o !== 1'b1) begin errors++; $display("FAIL wrapwr_d_pending: got %b expected 1", wr_pending_o); end
            end
        end
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            wr_valid_i = (c == 0);
            wr_on_i = e_on;
            wr_off_i = e_off;
            tick;
            wr_valid_i = 1'b0;
            checks++; if (pwm_o !== (c == 3000)) begin errors++; $display("FAIL wrapwr_e_pwm c=%0d: got %b", c, pwm_o); end
            if (c == 0) begin
                checks++; if (wr_pending_o !== 1'b0) begin errors++; $display("FAIL wrapwr_e_pending: got %b expected 0", wr_pending_o); end
            end
        end
    endtask

    task automatic test_invert_reset;
        pwm_reg_t e_on = '{1'b0, 12'd3000};
        pwm_reg_t e_off = '{1'b0, 12'd3001};
        pwm_reg_t on = '{1'b0, 12'd0};
        pwm_reg_t off = '{1'b0, 12'd2048};
        logic exp;
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            wr_valid_i = (c == 10);
            wr_on_i = on;
            wr_off_i = off;
            tick;
            wr_valid_i = 1'b0;
            checks++; if (pwm_o !== ref_level(12'(c), e_on, e_off)) begin errors++; $display("FAIL inv_old_pwm c=%0d: got %b", c, pwm_o); end
        end
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            invert_i = (c >= 1000 && c < 3000);
            tick;
            exp = (c < 2048) ^ (INV & invert_i);
            checks++; if (pwm_o !== exp) begin errors++; $display("FAIL inv_toggle_pwm c=%0d: got %b expected %b", c, pwm_o, exp); end
        end
        invert_i = 1'b0;
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            wr_valid_i = (c == 10);
            wr_on_i = 13'd5;
            wr_off_i = 13'd6;
            tick;
            wr_valid_i = 1'b0;
            exp = (c <= 1500) ? (c < 2048) : INV;
            checks++; if (pwm_o !== exp) begin errors++; $display("FAIL rst_mid_pwm c=%0d: got %b expected %b", c, pwm_o, exp); end
            if (c > 1500) begin
                checks++; if ({period_start_o, wr_pending_o} !== 2'b00) begin errors++; $display("FAIL rst_mid_flags c=%0d: got %b expected 00", c, {period_start_o, wr_pending_o}); end
            end
            if (c == 1500) begin
                rst_ni = 1'b0;
                #1;
                checks++; if ({pwm_o, period_start_o, wr_pending_o} !== 3'b000) begin errors++; $display("FAIL rst_mid_async: got %b expected 000", {pwm_o, period_start_o, wr_pending_o}); end
                invert_i = 1'b1;
                repeat (2) tick;
                checks++; if (pwm_o !== 1'b0) begin errors++; $display("FAIL rst_hold_inverted: got %b expected 0", pwm_o); end
                #2 rst_ni = 1'b1;
            end
        end
        for (int c = 0; c < 4096; c++) begin
            counter_i = 12'(c);
            tick;
            checks++; if ({pwm_o, period_start_o, wr_pending_o} !== {INV, c == 0, 1'b0}) begin errors++; $display("FAIL rst_shadow_lost c=%0d: got %b expected %b", c, {pwm_o, period_start_o, wr_pending_o}, {INV, c == 0, 1'b0}); end
        end
        invert_i = 1'b0;
    endtask

    initial begin
        test_reset;
        test_window;
        test_wrap_window;
        test_full;
        test_back_to_back;
        test_invert_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
